// File: rtl/load_store_aligner.sv
// load_store_aligner
//   Multi-cycle alignment unit between the core memory stage and a
//   word-organised synchronous data memory. One byte-addressed request is
//   accepted at a time. It becomes one word beat, or two when the access
//   crosses a word boundary. Each beat carries per-byte column enables.
//   Read beats are merged, then sign- or zero-extended.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready high only in IDLE)
//   req_addr              byte address
//   req_access            byte/half/word
//   req_write             1 = store
//   req_unsigned          1 = zero-extend loads
//   req_wdata             store data, right-justified
//   rsp_valid             one-cycle completion pulse (no backpressure)
//   rsp_rdata             extended load data; 0 for stores and errors
//   rsp_err               error flag, qualified by rsp_valid
//   mem_addr              word address
//   mem_wr_ena            write strobe
//   mem_col_ena           byte-lane enables
//   mem_wr_data           lane-positioned store data
//   mem_rd_data           read data, valid one cycle after its beat
//   dbg_state             current FSM state, for observation

package load_store_aligner_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'b00,
        MEM_ACCESS_HALF = 2'b01,
        MEM_ACCESS_WORD = 2'b10
    } mem_access_t;
endpackage

// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on state. The response is
// a single rsp_valid pulse, and the consumer must take it in that cycle.
module load_store_aligner
    import load_store_aligner_pkg::*;
#(
    parameter int L                = 128,
    parameter int W                = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [$clog2(L)+$clog2(W/8)-1:0]      req_addr,
    input  mem_access_t                           req_access,
    input  logic                                  req_write,
    input  logic                                  req_unsigned,
    input  logic [W-1:0]                          req_wdata,
    output logic                                  rsp_valid,
    output logic [W-1:0]                          rsp_rdata,
    output logic                                  rsp_err,
    output logic [$clog2(L)-1:0]                  mem_addr,
    output logic                                  mem_wr_ena,
    output logic [W/8-1:0]                        mem_col_ena,
    output logic [W-1:0]                          mem_wr_data,
    input  logic [W-1:0]                          mem_rd_data,
    output logic [2:0]                            dbg_state
);
    localparam int C  = W / 8;
    localparam int O  = $clog2(C);
    localparam int AW = $clog2(L);

    if (!(W == 32 || W == 64)) begin : g_bad_w
        $fatal(1, "load_store_aligner: W must be 32 or 64");
    end
    if (L < 2 || (L & (L - 1)) != 0) begin : g_bad_l
        $fatal(1, "load_store_aligner: L must be a power of two");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_CAP   = 3'd3,
        S_RESP  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Request decode
    logic [3:0]    req_size;
    logic          req_legal;
    logic [O-1:0]  req_off;
    logic [AW-1:0] req_word;
    logic          req_split;
    logic          req_err;

    always_comb begin
        req_size  = 4'd1;
        req_legal = 1'b1;
        case (req_access)
            MEM_ACCESS_BYTE: req_size = 4'd1;
            MEM_ACCESS_HALF: req_size = 4'd2;
            MEM_ACCESS_WORD: req_size = 4'd4;
            default:         req_legal = 1'b0;
        endcase
    end

    assign req_off   = req_addr[O-1:0];
    assign req_word  = req_addr[AW+O-1:O];
    assign req_split = (32'(req_off) + 32'(req_size)) > 32'(C);
    // Sizes are powers of two, so "offset mod size" is a mask test.
    assign req_err   = !req_legal ||
                       (!ALLOW_MISALIGNED && ((32'(req_off) & (32'(req_size) - 32'd1)) != 32'd0));

    // Latched request
    logic [O-1:0]  q_off;
    logic [AW-1:0] q_word;
    logic [3:0]    q_size;
    logic          q_write;
    logic          q_unsigned;
    logic          q_split;
    logic [W-1:0]  q_wdata;
    logic [W-1:0]  lo_q;

    // The outputs are registered. On the accept edge the beat-0 values must
    // come from the live request, and after that from the latched copy.
    logic          use_req;
    logic [O-1:0]  src_off;
    logic [AW-1:0] src_word;
    logic [3:0]    src_size;
    logic          src_write;
    logic [W-1:0]  src_wdata;
    logic [2*C-1:0] lane_wide;
    logic [2*W-1:0] data_wide;

    assign use_req   = (state_q == S_IDLE);
    assign src_off   = use_req ? req_off   : q_off;
    assign src_word  = use_req ? req_word  : q_word;
    assign src_size  = use_req ? req_size  : q_size;
    assign src_write = use_req ? req_write : q_write;
    assign src_wdata = use_req ? req_wdata : q_wdata;

    // The low half of each double-width vector is beat 0 and the high half
    // is beat 1. The high half equals the right-shift by (C-o) used for the
    // second beat.
    assign lane_wide = (((2*C)'(1) << src_size) - (2*C)'(1)) << src_off;
    assign data_wide = {{W{1'b0}}, src_wdata} << {src_off, 3'b000};

    // Load merge. In CAP the final word is still on mem_rd_data, so it is
    // used directly rather than through a capture register.
    logic [2*W-1:0] pair;
    logic [W-1:0]   load_bytes;
    logic           fill;
    logic [W-1:0]   load_result;

    assign pair       = q_split ? {mem_rd_data, lo_q} : {{W{1'b0}}, mem_rd_data};
    assign load_bytes = W'(pair >> {q_off, 3'b000});

    always_comb begin
        case (q_size)
            4'd1:    fill = load_bytes[7];
            4'd2:    fill = load_bytes[15];
            default: fill = load_bytes[31];
        endcase
        if (q_unsigned) fill = 1'b0;
        load_result = '0;
        for (int i = 0; i < C; i++) begin
            if (i < int'(q_size)) load_result[8*i +: 8] = load_bytes[8*i +: 8];
            else                  load_result[8*i +: 8] = {8{fill}};
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = req_err ? S_ERR : S_BEAT0;
            S_BEAT0: begin
                if (q_split)       state_d = S_BEAT1;
                else if (!q_write) state_d = S_CAP;
                else               state_d = S_RESP;
            end
            S_BEAT1: state_d = q_write ? S_RESP : S_CAP;
            S_CAP:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. The next register values are decoded from the next state.
    logic [AW-1:0] mem_addr_d;
    logic          mem_wr_ena_d;
    logic [C-1:0]  mem_col_ena_d;
    logic [W-1:0]  mem_wr_data_d;
    logic          rsp_valid_d;
    logic          rsp_err_d;
    logic [W-1:0]  rsp_rdata_d;

    always_comb begin
        mem_addr_d    = mem_addr;
        mem_wr_ena_d  = 1'b0;
        mem_col_ena_d = '0;
        mem_wr_data_d = '0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
        case (state_d)
            S_BEAT0: begin
                mem_addr_d    = src_word;
                mem_wr_ena_d  = src_write;
                mem_col_ena_d = lane_wide[C-1:0];
                mem_wr_data_d = data_wide[W-1:0];
            end
            S_BEAT1: begin
                mem_addr_d    = src_word + AW'(1);  // wraps from L-1 to 0
                mem_wr_ena_d  = src_write;
                mem_col_ena_d = lane_wide[2*C-1:C];
                mem_wr_data_d = data_wide[2*W-1:W];
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = (state_q == S_CAP) ? load_result : '0;
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_wr_ena  <= 1'b0;
            mem_col_ena <= '0;
            mem_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            mem_addr    <= mem_addr_d;
            mem_wr_ena  <= mem_wr_ena_d;
            mem_col_ena <= mem_col_ena_d;
            mem_wr_data <= mem_wr_data_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_off      <= '0;
            q_word     <= '0;
            q_size     <= 4'd1;
            q_write    <= 1'b0;
            q_unsigned <= 1'b0;
            q_split    <= 1'b0;
            q_wdata    <= '0;
            lo_q       <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                q_off      <= req_off;
                q_word     <= req_word;
                q_size     <= req_size;
                q_write    <= req_write;
                q_unsigned <= req_unsigned;
                q_split    <= req_split;
                q_wdata    <= req_wdata;
            end
            // The word read by beat 0 is on mem_rd_data during BEAT1.
            if (state_q == S_BEAT1) lo_q <= mem_rd_data;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_aligner.sv
module tb_load_store_aligner;
    import load_store_aligner_pkg::*;

    localparam int L  = 128;
    localparam int W  = 32;
    localparam int C  = 4;
    localparam int AW = 7;
    localparam int BA = 9;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT with misaligned support ----------------
    logic          req_valid    = 1'b0;
    logic          req_ready;
    logic [BA-1:0] req_addr     = '0;
    mem_access_t   req_access   = MEM_ACCESS_BYTE;
    logic          req_write    = 1'b0;
    logic          req_unsigned = 1'b0;
    logic [W-1:0]  req_wdata    = '0;
    logic          rsp_valid, rsp_err;
    logic [W-1:0]  rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_ena;
    logic [C-1:0]  mem_col_ena;
    logic [W-1:0]  mem_wr_data;
    logic [W-1:0]  mem_rd_data;
    logic [2:0]    dbg_state;

    load_store_aligner #(.L(L), .W(W), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_access(req_access), .req_write(req_write), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_col_ena(mem_col_ena),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- DUT without misaligned support ----------------
    logic          na_req_valid    = 1'b0;
    logic          na_req_ready;
    logic [BA-1:0] na_req_addr     = '0;
    mem_access_t   na_req_access   = MEM_ACCESS_BYTE;
    logic          na_req_write    = 1'b0;
    logic          na_req_unsigned = 1'b0;
    logic [W-1:0]  na_req_wdata    = '0;
    logic          na_rsp_valid, na_rsp_err;
    logic [W-1:0]  na_rsp_rdata;
    logic [AW-1:0] na_mem_addr;
    logic          na_mem_wr_ena;
    logic [C-1:0]  na_mem_col_ena;
    logic [W-1:0]  na_mem_wr_data;
    logic [W-1:0]  na_mem_rd_data;
    logic [2:0]    na_dbg_state;

    assign na_mem_rd_data = 32'h4433_2211;  // every word reads the same

    load_store_aligner #(.L(L), .W(W), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_addr(na_req_addr),
        .req_access(na_req_access), .req_write(na_req_write), .req_unsigned(na_req_unsigned),
        .req_wdata(na_req_wdata),
        .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata), .rsp_err(na_rsp_err),
        .mem_addr(na_mem_addr), .mem_wr_ena(na_mem_wr_ena), .mem_col_ena(na_mem_col_ena),
        .mem_wr_data(na_mem_wr_data), .mem_rd_data(na_mem_rd_data),
        .dbg_state(na_dbg_state)
    );

    // ---------------- synchronous memory model ----------------
    logic [W-1:0]  mem [L];
    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [W-1:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_wr_ena) begin
            for (int i = 0; i < C; i++)
                if (mem_col_ena[i]) mem[mem_addr][8*i +: 8] <= mem_wr_data[8*i +: 8];
        end
        mem_rd_data <= mem[mem_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic         id;
        logic         err;
        logic [W-1:0] rdata;
        logic [31:0]  cyc;
    } rsp_t;

    typedef struct packed {
        logic          id;
        logic [AW-1:0] addr;
        logic [C-1:0]  col;
        logic [W-1:0]  data;
        logic          we;
    } beat_t;

    rsp_t  exp_q[$];
    beat_t beat_q[$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    rsp_t  mon_r, mon_er;
    beat_t mon_b, mon_eb;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid || na_rsp_valid) begin
                mon_r.id    = na_rsp_valid;
                mon_r.err   = na_rsp_valid ? na_rsp_err   : rsp_err;
                mon_r.rdata = na_rsp_valid ? na_rsp_rdata : rsp_rdata;
                mon_r.cyc   = 32'(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got %h, expected no response", mon_r);
                end else begin
                    mon_er = exp_q.pop_front();
                    check("rsp{id,err,rdata,cycle}", 96'(mon_r), 96'(mon_er));
                end
            end
            if (mem_col_ena != '0 || na_mem_col_ena != '0) begin
                mon_b.id   = (na_mem_col_ena != '0);
                mon_b.addr = mon_b.id ? na_mem_addr    : mem_addr;
                mon_b.col  = mon_b.id ? na_mem_col_ena : mem_col_ena;
                mon_b.data = mon_b.id ? na_mem_wr_data : mem_wr_data;
                mon_b.we   = mon_b.id ? na_mem_wr_ena  : mem_wr_ena;
                if (beat_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got %h, expected no beat", mon_b);
                end else begin
                    mon_eb = beat_q.pop_front();
                    check("beat{id,addr,col,data,we}", 96'(mon_b), 96'(mon_eb));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic beat(input bit na, input logic [AW-1:0] a, input logic [C-1:0] col,
                        input logic [W-1:0] d, input bit we);
        beat_t b;
        b.id = na; b.addr = a; b.col = col; b.data = d; b.we = we;
        beat_q.push_back(b);
    endtask

    task automatic issue(input bit na, input logic [BA-1:0] addr, input mem_access_t acc,
                         input bit wr, input bit uns, input logic [W-1:0] wd,
                         input bit expect_rsp, input bit err, input logic [W-1:0] rdata,
                         input int lat);
        int   waited;
        rsp_t r;
        waited = 0;
        @(negedge clk);
        while (!(na ? na_req_ready : req_ready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_timeout: got ready=0 for 50 cycles, expected ready=1");
            return;
        end
        if (na) begin
            na_req_valid = 1'b1; na_req_addr = addr; na_req_access = acc;
            na_req_write = wr; na_req_unsigned = uns; na_req_wdata = wd;
        end else begin
            req_valid = 1'b1; req_addr = addr; req_access = acc;
            req_write = wr; req_unsigned = uns; req_wdata = wd;
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        na_req_valid = 1'b0;
        if (expect_rsp) begin
            r.id = na; r.err = err; r.rdata = rdata; r.cyc = 32'(cyc + lat - 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d rsp / %0d beats pending, expected 0",
                     exp_q.size(), beat_q.size());
            exp_q.delete();
            beat_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outputs"},
              96'({rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wr_ena, mem_col_ena, mem_wr_data}),
              96'(0));
        check({tag, "_ready_state"}, 96'({req_ready, dbg_state}), 96'(4'b1000));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        preload(7'd0,   32'h1280_3456);
        preload(7'd1,   32'h4433_2211);
        preload(7'd2,   32'h8877_6655);
        preload(7'd3,   32'h0000_0000);
        preload(7'd4,   32'h0000_0000);
        preload(7'd127, 32'hA5A5_A5A5);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // aligned word load
        beat(0, 7'd1, 4'b1111, 32'h0, 0);
        issue(0, 9'h004, MEM_ACCESS_WORD, 0, 0, 32'h0, 1, 0, 32'h4433_2211, 3);
        // split word load
        beat(0, 7'd1, 4'b1000, 32'h0, 0);
        beat(0, 7'd2, 4'b0111, 32'h0, 0);
        issue(0, 9'h007, MEM_ACCESS_WORD, 0, 0, 32'h0, 1, 0, 32'h7766_5544, 4);
        // byte extension
        beat(0, 7'd0, 4'b0100, 32'h0, 0);
        issue(0, 9'h002, MEM_ACCESS_BYTE, 0, 0, 32'h0, 1, 0, 32'hFFFF_FF80, 3);
        beat(0, 7'd0, 4'b0100, 32'h0, 0);
        issue(0, 9'h002, MEM_ACCESS_BYTE, 0, 1, 32'h0, 1, 0, 32'h0000_0080, 3);
        // misaligned half inside one word, signed
        beat(0, 7'd0, 4'b0110, 32'h0, 0);
        issue(0, 9'h001, MEM_ACCESS_HALF, 0, 0, 32'h0, 1, 0, 32'hFFFF_8034, 3);
        // split half, unsigned
        beat(0, 7'd1, 4'b1000, 32'h0, 0);
        beat(0, 7'd2, 4'b0001, 32'h0, 0);
        issue(0, 9'h007, MEM_ACCESS_HALF, 0, 1, 32'h0, 1, 0, 32'h0000_5544, 4);
        // aligned store then load back
        beat(0, 7'd2, 4'b1111, 32'hCAFE_F00D, 1);
        issue(0, 9'h008, MEM_ACCESS_WORD, 1, 0, 32'hCAFE_F00D, 1, 0, 32'h0, 2);
        beat(0, 7'd2, 4'b1111, 32'h0, 0);
        issue(0, 9'h008, MEM_ACCESS_WORD, 0, 0, 32'h0, 1, 0, 32'hCAFE_F00D, 3);
        // wrap-around split store then loads back
        beat(0, 7'd127, 4'b1000, 32'hEF00_0000, 1);
        beat(0, 7'd0,   4'b0001, 32'h0000_00BE, 1);
        issue(0, 9'h1FF, MEM_ACCESS_HALF, 1, 0, 32'h0000_BEEF, 1, 0, 32'h0, 3);
        beat(0, 7'd127, 4'b1000, 32'h0, 0);
        beat(0, 7'd0,   4'b0001, 32'h0, 0);
        issue(0, 9'h1FF, MEM_ACCESS_HALF, 0, 1, 32'h0, 1, 0, 32'h0000_BEEF, 4);
        beat(0, 7'd127, 4'b1000, 32'h0, 0);
        beat(0, 7'd0,   4'b0001, 32'h0, 0);
        issue(0, 9'h1FF, MEM_ACCESS_HALF, 0, 0, 32'h0, 1, 0, 32'hFFFF_BEEF, 4);
        // illegal access encoding: error, no beat
        issue(0, 9'h000, mem_access_t'(2'b11), 0, 0, 32'h0, 1, 1, 32'h0, 1);
        // byte stores; upper wdata bits must be masked by the lane enable
        beat(0, 7'd3, 4'b0010, 32'h0000_AB00, 1);
        issue(0, 9'h00D, MEM_ACCESS_BYTE, 1, 0, 32'h0000_00AB, 1, 0, 32'h0, 2);
        beat(0, 7'd3, 4'b0001, 32'h1234_5677, 1);
        issue(0, 9'h00C, MEM_ACCESS_BYTE, 1, 0, 32'h1234_5677, 1, 0, 32'h0, 2);
        beat(0, 7'd3, 4'b1111, 32'h0, 0);
        issue(0, 9'h00C, MEM_ACCESS_WORD, 0, 0, 32'h0, 1, 0, 32'h0000_AB77, 3);
        beat(0, 7'd3, 4'b0010, 32'h0, 0);
        issue(0, 9'h00D, MEM_ACCESS_BYTE, 0, 0, 32'h0, 1, 0, 32'hFFFF_FFAB, 3);
        wait_idle();

        // reset during beat 1 of a split store: only beat 0 lands
        beat(0, 7'd3, 4'b1100, 32'h3344_0000, 1);
        issue(0, 9'h00E, MEM_ACCESS_WORD, 1, 0, 32'h1122_3344, 0, 0, 32'h0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsplit_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        wait_idle();
        check("mem3_after_reset", 96'(mem[3]), 96'(32'h3344_AB77));
        check("mem4_after_reset", 96'(mem[4]), 96'(32'h0000_0000));

        // no-misaligned instance
        beat(1, 7'd1, 4'b1100, 32'h0, 0);
        issue(1, 9'h006, MEM_ACCESS_HALF, 0, 0, 32'h0, 1, 0, 32'h0000_4433, 3);
        issue(1, 9'h006, MEM_ACCESS_WORD, 0, 0, 32'h0, 1, 1, 32'h0, 1);
        issue(1, 9'h001, MEM_ACCESS_HALF, 0, 0, 32'h0, 1, 1, 32'h0, 1);
        beat(1, 7'd1, 4'b1111, 32'h0, 0);
        issue(1, 9'h004, MEM_ACCESS_WORD, 0, 1, 32'h0, 1, 0, 32'h4433_2211, 3);
        wait_idle();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_aligner.md
# load_store_aligner

Multi-cycle load/store alignment unit between the core's memory stage and a word-organised synchronous data memory. It accepts one byte-addressed request at a time and issues one or two word beats with per-byte column enables. Accesses that straddle a word boundary are split into two beats. Read beats are merged and then sign- or zero-extended. It generalises the single-cycle column decoder to W=32/64 and adds misaligned-access handling.

## Interface
- L, 128: memory depth in words; must be a power of two.
- W, 32: data width; only 32 or 64 are legal. C=W/8 byte lanes, O=$clog2(C).
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing accesses; 0 = non-naturally-aligned access returns an error.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid & req_ready.
- req_addr  in  $clog2(L)+O  byte address.
- req_access  in  mem_access_t  MEM_ACCESS_BYTE/HALF/WORD, size s = 1/2/4 bytes.
- req_write  in  1  1 = store, 0 = load.
- req_unsigned  in  1  load zero-extends when 1.
- req_wdata  in  W  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  W  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid.
- mem_addr  out  $clog2(L)  word address.
- mem_wr_ena  out  1  write strobe.
- mem_col_ena  out  C  byte-lane enables.
- mem_wr_data  out  W  lane-positioned store data.
- mem_rd_data  in  W  read data; valid one cycle after the beat cycle.

## Operation
- Elaboration: W not in {32,64}, or L not a power of two, triggers $fatal.
- On accept, latch all request fields and compute the following:
  - o = addr[O-1:0], word index a = addr>>O.
  - split = (o+s > C).
  - err = illegal access encoding, or (!ALLOW_MISALIGNED and o mod s ≠ 0).
- States and transitions:
  - IDLE → ERR when err.
  - IDLE → BEAT0 otherwise.
  - BEAT0 → BEAT1 when split.
  - BEAT0 → CAP when the request is a load.
  - BEAT0 → RESP when the request is a store.
  - BEAT1 → CAP for a load, → RESP for a store.
  - CAP → RESP.
  - ERR → IDLE with rsp_valid=1 and rsp_err=1.
  - RESP → IDLE.
- BEAT0 drives:
  - mem_addr = a.
  - mem_col_ena = (((1<<s)-1)<<o) truncated to C bits.
  - mem_wr_data = wdata<<(8·o).
  - mem_wr_ena = write.
- BEAT1 drives:
  - mem_addr = (a+1) mod L; the word after L-1 is 0.
  - mem_col_ena = ((1<<s)-1)>>(C-o).
  - mem_wr_data = wdata>>(8·(C-o)).
  - mem_wr_ena = write.
- In all other states: mem_col_ena=0, mem_wr_ena=0, mem_wr_data=0; mem_addr holds its last value.
- Read capture:
  - The cycle after BEAT0 (BEAT1 or CAP) latches mem_rd_data as lo.
  - The cycle after BEAT1 (CAP) latches hi.
- Load merge: result byte i = byte (o+i) of {hi,lo}, for i<s. Bytes at i≥s are filled with the sign of byte s-1, or with 0 when req_unsigned. At W=64, a word load is extended the same way.
- RESP: rsp_valid=1 for exactly one cycle, rsp_err=0; rsp_rdata = merged load result, or 0 for a store.
- No response backpressure; the consumer must take the response in its pulse cycle.

## Timing
- Take the accept edge as cycle 0.
  - Aligned load: BEAT0 in cycle 1, CAP in cycle 2, rsp_valid in cycle 3.
  - Split load: rsp_valid in cycle 4.
  - Aligned store: rsp_valid in cycle 2.
  - Split store: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1, and no memory beat is issued.
- req_ready is combinational from state and is high in every IDLE cycle.
- A new request can be accepted in the cycle after rsp_valid, since RESP and ERR both return to IDLE.
- All memory-side outputs and rsp_* are registered.
- Reset (async):
  - State goes to IDLE.
  - rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wr_ena, mem_col_ena and mem_wr_data all go to 0.
  - req_ready reads 1.
  - A reset during BEAT0 or BEAT1 drops that beat immediately, with no response; a half-completed split store leaves only its first beat written.

## Test plan
- Aligned load, W=32: mem[1]=0x44332211, load WORD at 0x004. Expect one beat with mem_addr=1 and col_ena=4'b1111; rsp_rdata=0x44332211 in cycle 3.
- Split load: mem[1]=0x44332211, mem[2]=0x88776655, load WORD at 0x007. Expect beats (1, 4'b1000) then (2, 4'b0111); rsp_rdata=0x77665544 in cycle 4.
- Extension: mem[0]=0x12803456, load BYTE at 0x002. Signed gives 0xFFFFFF80; unsigned gives 0x00000080.
- Wrap store, L=128: store HALF 0xBEEF at 0x1FF. Expect beat (127, 4'b1000, 0xEF000000) then (0, 4'b0001, 0x000000BE); rsp_valid in cycle 3.
- ALLOW_MISALIGNED=0: load WORD at 0x006. Expect rsp_err=1 in cycle 1, rsp_rdata=0, and mem_col_ena=0 throughout.
- Reset mid-split: deassert rst_n during BEAT1 of a split store. Expect all outputs 0 asynchronously, no rsp_valid, req_ready=1; only the BEAT0 bytes are changed in memory.
